// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//               with divide-by-zero / signed-overflow fast path. Optional result
//               reuse cache enabled by the DIV_REUSE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      MDU_op_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] numerator_i,
    input  logic [XLEN-1:0] denominator_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem, dvd, dsr;
    logic             num_neg, den_neg;

    logic            accept, op_signed, div_zero, overflow, reuse_hit, fast;
    logic [XLEN-1:0] num_mag, den_mag, hit_q, hit_r;
    logic [XLEN:0]   shifted, diff;
    logic            no_borrow;
    logic            unused_op;

    // Bit 1 (DIV vs REM) only matters to the MDU's result select.
    assign unused_op = MDU_op_i[1];

    assign accept    = (state == IDLE) && start_i && MDU_op_i[2];
    assign op_signed = !MDU_op_i[0];
    assign div_zero  = (denominator_i == '0);
    assign overflow  = op_signed && (numerator_i == INT_MIN) && (denominator_i == '1);
    assign fast      = reuse_hit || div_zero || overflow;
    assign num_mag   = (op_signed && numerator_i[XLEN-1])   ? -numerator_i   : numerator_i;
    assign den_mag   = (op_signed && denominator_i[XLEN-1]) ? -denominator_i : denominator_i;

    assign shifted   = {rem, dvd[XLEN-1]};
    assign diff      = shifted - {1'b0, dsr};
    assign no_borrow = !diff[XLEN];

    assign done_o = (state == DONE);
    assign busy_o = (state == BUSY) || (state == SIGN);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = fast ? DONE : BUSY;
            BUSY: begin
                if (!start_i)                state_next = IDLE;
                else if (count == LAST_STEP) state_next = SIGN;
            end
            SIGN: state_next = start_i ? DONE : IDLE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quotient_o  <= '0;
            remainder_o <= '0;
            count       <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            num_neg     <= 1'b0;
            den_neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    num_neg <= op_signed & numerator_i[XLEN-1];
                    den_neg <= op_signed & denominator_i[XLEN-1];
                    dvd     <= num_mag;
                    dsr     <= den_mag;
                    rem     <= '0;
                    count   <= '0;
                    if (reuse_hit) begin
                        quotient_o  <= hit_q;
                        remainder_o <= hit_r;
                    end else if (div_zero) begin
                        quotient_o  <= '1;
                        remainder_o <= numerator_i;
                    end else if (overflow) begin
                        quotient_o  <= INT_MIN;
                        remainder_o <= '0;
                    end
                end
                // dvd shifts out dividend bits and collects quotient bits.
                BUSY: if (start_i) begin
                    rem   <= no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    dvd   <= {dvd[XLEN-2:0], no_borrow};
                    count <= count + 1'b1;
                end
                SIGN: if (start_i) begin
                    quotient_o  <= (num_neg ^ den_neg) ? -dvd : dvd;
                    remainder_o <= num_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_REUSE_EN
    logic            reuse_valid, signed_q, reuse_signed;
    logic [XLEN-1:0] num_q, den_q, reuse_num, reuse_den;

    assign reuse_hit = reuse_valid && (reuse_signed == op_signed) &&
                       (reuse_num == numerator_i) && (reuse_den == denominator_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reuse_valid  <= 1'b0;
            signed_q     <= 1'b0;
            reuse_signed <= 1'b0;
            num_q        <= '0;
            den_q        <= '0;
            reuse_num    <= '0;
            reuse_den    <= '0;
            hit_q        <= '0;
            hit_r        <= '0;
        end else begin
            if (accept) begin
                num_q    <= numerator_i;
                den_q    <= denominator_i;
                signed_q <= op_signed;
            end
            if (busy_o && !start_i) begin
                reuse_valid <= 1'b0;
            end else if (state == DONE) begin
                reuse_valid  <= 1'b1;
                reuse_signed <= signed_q;
                reuse_num    <= num_q;
                reuse_den    <= den_q;
                hit_q        <= quotient_o;
                hit_r        <= remainder_o;
            end
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign hit_q     = '0;
    assign hit_r     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic        start;
    logic [31:0] num, den;
    logic [31:0] quotient, remainder;
    logic        done, busy;

    seq_divider #(.XLEN(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .MDU_op_i      (op),
        .start_i       (start),
        .numerator_i   (num),
        .denominator_i (den),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .done_o        (done),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef DIV_REUSE_EN
    localparam int B2B_LAT  = 2;
    localparam int B2B_BUSY = 0;
`else
    localparam int B2B_LAT  = 35;
    localparam int B2B_BUSY = 33;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; the following posedge is the accept edge (cycle 0).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int lat);
        exp_t x;
        op    = o;
        num   = a;
        den   = b;
        start = 1'b1;
        x.q   = eq;
        x.r   = er;
        x.cyc = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int exp_busy);
        int bc   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 80 cycles, expected done");
        end else if (exp_busy >= 0) begin
            chk("busy_cycles", bc, exp_busy);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int lat, input int bsy);
        issue(o, a, b, eq, er, lat);
        wait_done(bsy);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; num = '0; den = '0;
        repeat (3) @(negedge clk);
        chk("reset_q", quotient, 32'h0);
        chk("reset_r", remainder, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run(3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 34, 33);
        run(3'b100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 33);
        run(3'b101, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 32'h1, 34, 33);
        run(3'b101, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1, 0);
        run(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 33);

        // Non-divide funct3 must be ignored.
        op = 3'b000; num = 32'd50; den = 32'd5; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("nondiv_busy", {31'b0, busy}, 32'h0);
        start = 1'b0;
        @(negedge clk);

        // Flush: start dropped in cycle 10.
        op = 3'b100; num = 32'd100; den = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_q_held", quotient, 32'h0);
        chk("abort_r_held", remainder, 32'h80000000);
        repeat (40) @(negedge clk);
        run(3'b100, 32'd9, 32'd3, 32'd3, 32'd0, 34, 33);

        // Reset in cycle 20 of an op.
        op = 3'b100; num = 32'd100; den = 32'd7; start = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("midrst_q", quotient, 32'h0);
        chk("midrst_r", remainder, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back DIV then REM with start held.
        issue(3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        wait_done(33);
        issue(3'b110, 32'd100, 32'd7, 32'd14, 32'd2, B2B_LAT);
        wait_done(B2B_BUSY);
        start = 1'b0;
        @(negedge clk);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(3'b110, 32'd100, 32'd7, 32'd14, 32'd2, 34, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 32-bit radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits directly under the MDU. The MDU holds start_i high while it stalls the pipeline, and releases the stall on done_o.
- Produces quotient and remainder together. The MDU selects one by funct3.
- Implements RISC-V divide-by-zero and signed-overflow semantics with a short fast path.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- MDU_op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Bit2=0 means not a divide.
- start_i  input  1  request. Held high by the MDU until done_o is seen.
- numerator_i  input  XLEN  dividend (rs1).
- denominator_i  input  XLEN  divisor (rs2).
- quotient_o  output  XLEN  registered quotient. Held until the next accepted op.
- remainder_o  output  XLEN  registered remainder. Held until the next accepted op.
- done_o  output  1  one-cycle pulse; results valid in the same cycle.
- busy_o  output  1  high in BUSY and SIGN states.

Behaviour:
- Reset (synchronous): state=IDLE, quotient_o=0, remainder_o=0, done_o=0, busy_o=0, internal counters cleared, reuse entry invalid. rst_i mid-operation: IDLE at the next edge, no done_o.
- Accept condition: start_i=1 && MDU_op_i[2]=1 in IDLE. At that edge, latch operands and signedness (signed = !MDU_op_i[0]). If MDU_op_i[2]=0, stay IDLE.
- States:
  - IDLE:
    - Accept with divisor==0 -> DONE. Result: q=all ones, r=dividend.
    - Accept with signed, dividend=0x80000000 and divisor=0xFFFFFFFF -> DONE. Result: q=0x80000000, r=0.
    - Any other accept -> BUSY. Load magnitudes (two's-complement absolute value when signed), count=0.
  - BUSY:
    - One restoring step per cycle: shift {rem,dvd} left 1, trial-subtract divisor magnitude, set q bit if no borrow.
    - After XLEN steps (count==XLEN-1) -> SIGN.
  - SIGN:
    - Negate q if signed and operand signs differ.
    - Negate r if signed and dividend negative (remainder takes the dividend's sign).
    - Write quotient_o/remainder_o, -> DONE.
  - DONE: done_o=1 for exactly this cycle, -> IDLE.
- Timing:
  - Start accepted in cycle 0. Normal op: done_o in cycle XLEN+2 (34).
  - Fast path (div-by-zero, overflow): done_o in cycle 1.
- Back-to-back: start_i still high in the IDLE cycle after DONE is accepted as a new op. There is no dead cycle beyond that IDLE cycle.
- Abort: start_i low during BUSY or SIGN -> IDLE at the next edge. No done_o; quotient_o/remainder_o unchanged. This is the pipeline-flush path.
- Operand or MDU_op_i changes after acceptance are ignored.
- quotient_o/remainder_o change only in DONE (or fast-path entry to DONE) and on reset.

Optional Feature:
- DIV_REUSE_EN.
- When defined:
  - On each completed op, store numerator, denominator, signedness, q and r, and mark the entry valid.
  - An accept whose operands and signedness match the valid entry goes IDLE -> DONE with the stored results: done_o in cycle 1. This covers DIV followed by REM on the same operands.
  - Reset and abort invalidate the entry. Only completed ops update it.
- When undefined: no storage; every op takes the normal or fast-path latency.

Test Plan:
1. DIV 100/7 (0x64, 0x7) -> quotient_o=14, remainder_o=2. done_o high only in cycle 34. busy_o high cycles 1-33.
2. DIV 0xFFFFFFF9/0x2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. DIVU with the same operands -> q=0x7FFFFFFC, r=0x1. Both done_o in cycle 34.
3. DIVU 0x12345678/0 -> q=0xFFFFFFFF, r=0x12345678, done_o in cycle 1. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, done_o in cycle 1.
4. DIVU 0x80000000/0xFFFFFFFF -> q=0, r=0x80000000, done_o in cycle 34, since the overflow fast path applies to signed ops only.
5. Flush and reset:
   - DIV 100/7, start_i dropped in cycle 10 -> no done_o, IDLE in cycle 11, outputs unchanged.
   - A new DIV 9/3 then gives q=3, r=0.
   - rst_i in cycle 20 of an op -> all outputs 0 next cycle, no done_o.
6. Back-to-back DIV 100/7 then REM 100/7 with start_i held:
   - Without DIV_REUSE_EN: second done_o 35 cycles after the first.
   - With DIV_REUSE_EN: second done_o 2 cycles after the first, r=2.
   - After rst_i, the same REM takes the full 34 cycles.
